// File: rtl/qam16_demapper_if.sv
// Bus bundle for the QAM-16 demapper: decided-symbol input side and serial bit output side.
interface qam16_demapper_if #(
   parameter int width_in = 16
);
   logic signed [width_in-1:0] x_in;
   logic signed [width_in-1:0] y_in;
   logic                       sym_valid;
   logic                       bit_ready;
   logic                       bit_out;
   logic                       bit_valid;

   // Symbol side has no backpressure: one symbol per sym_valid cycle.
   // Bit side transfers on bit_valid && bit_ready; once bit_valid rises,
   // bit_out is held until accepted.
   modport master (
      output x_in, y_in, sym_valid, bit_ready,
      input  bit_out, bit_valid
   );

   modport slave (
      input  x_in, y_in, sym_valid, bit_ready,
      output bit_out, bit_valid
   );
endinterface

// File: rtl/qam16_demapper.sv
// QAM-16 Gray demapper: slicer decisions -> 4-bit symbols -> FIFO -> MSB-first serial stream.
module qam16_demapper #(
   parameter int width_in   = 16,
   parameter int fifo_depth = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   qam16_demapper_if.slave    bus,
   output logic [3:0]         sym_out,
   output logic               fifo_full,
   output logic               overflow,
   output logic               inv_sym,
   output logic [15:0]        sym_count,
   output logic               state_o
);

   localparam int AW = $clog2(fifo_depth);
   localparam int CW = AW + 1;

   localparam logic signed [width_in-1:0] LVL_N3    = width_in'(-12288);
   localparam logic signed [width_in-1:0] LVL_N1    = width_in'(-4096);
   localparam logic signed [width_in-1:0] LVL_P1    = width_in'(4096);
   localparam logic signed [width_in-1:0] LVL_P3    = width_in'(12288);
   localparam logic signed [width_in-1:0] OUTER_POS = width_in'(8192);
   localparam logic signed [width_in-1:0] OUTER_NEG = width_in'(-8192);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   function automatic logic [1:0] axis_code(input logic signed [width_in-1:0] v);
      logic outer;
      outer = (v >= OUTER_POS) || (v < OUTER_NEG);
      if (v[width_in-1]) return outer ? 2'b00 : 2'b01;
      else               return outer ? 2'b10 : 2'b11;
   endfunction

   function automatic logic is_exact(input logic signed [width_in-1:0] v);
      return (v == LVL_N3) || (v == LVL_N1) || (v == LVL_P1) || (v == LVL_P3);
   endfunction

   logic [3:0]    mem_q [fifo_depth];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   sym_count_q, sym_count_d;
   logic          overflow_q, overflow_d;
   logic          inv_sym_q, inv_sym_d;

   state_t        state_q;
   logic [3:0]    shift_q;
   logic [1:0]    idx_q;
   logic          bit_out_q;
   logic          bit_valid_q;

   logic          empty, full, push, pop;
   logic [3:0]    sym_in, rd_data;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(fifo_depth));
   assign rd_data = mem_q[rd_ptr_q];
   assign sym_in  = {axis_code(bus.x_in), axis_code(bus.y_in)};

   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign pop  = !empty && ((state_q == S_IDLE) ||
                            (bit_valid_q && bus.bit_ready && (idx_q == 2'd3)));
   assign push = bus.sym_valid && (!full || pop);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      sym_count_d = sym_count_q;
      overflow_d  = overflow_q;
      inv_sym_d   = inv_sym_q;
      if (push) begin
         wr_ptr_d    = wr_ptr_q + AW'(1);
         sym_count_d = sym_count_q + 16'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (bus.sym_valid && !push) overflow_d = 1'b1;
      if (bus.sym_valid && !(is_exact(bus.x_in) && is_exact(bus.y_in))) inv_sym_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sym_count_q <= '0;
         overflow_q  <= 1'b0;
         inv_sym_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sym_count_q <= sym_count_d;
         overflow_q  <= overflow_d;
         inv_sym_q   <= inv_sym_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= sym_in;
   end

   // Serializer: bit_out is pre-computed so it is valid the cycle bit_valid rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shift_q     <= 4'd0;
         idx_q       <= 2'd0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  shift_q     <= rd_data;
                  idx_q       <= 2'd0;
                  bit_out_q   <= rd_data[3];
                  bit_valid_q <= 1'b1;
                  state_q     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.bit_ready) begin
                  if (idx_q == 2'd3) begin
                     if (!empty) begin
                        shift_q   <= rd_data;
                        idx_q     <= 2'd0;
                        bit_out_q <= rd_data[3];
                     end else begin
                        bit_valid_q <= 1'b0;
                        bit_out_q   <= 1'b0;
                        state_q     <= S_IDLE;
                     end
                  end else begin
                     idx_q     <= idx_q + 2'd1;
                     bit_out_q <= shift_q[2'd2 - idx_q];
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               bit_valid_q <= 1'b0;
               bit_out_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bit_out   = bit_out_q;
   assign bus.bit_valid = bit_valid_q;
   assign sym_out       = shift_q;
   assign fifo_full     = full;
   assign overflow      = overflow_q;
   assign inv_sym       = inv_sym_q;
   assign sym_count     = sym_count_q;
   assign state_o       = (state_q == S_SHIFT);

endmodule

// File: doc/qam16_demapper.md
# qam16_demapper

QAM-16 receiver stage that sits directly downstream of the constellation slicer. It takes each decided (I,Q) point in Q12 format (±4096 = ±1, ±12288 = ±3) and Gray-demaps it to a 4-bit symbol. Symbols are buffered in a small FIFO, then serialized MSB-first onto a valid/ready bit stream for the descrambler/framer.

## Interface
- `width_in`, 16: width of the decided I/Q inputs, two's complement Q12.
- `fifo_depth`, 8: symbol FIFO depth in 4-bit entries; power of two, 2..64.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x_in`  in  width_in  decided I value, signed.
- `y_in`  in  width_in  decided Q value, signed.
- `sym_valid`  in  1  x_in/y_in valid this cycle; one symbol per high cycle.
- `bit_ready`  in  1  downstream accepts bit_out this cycle.
- `bit_out`  out  1  serial data bit.
- `bit_valid`  out  1  bit_out valid.
- `sym_out`  out  4  symbol currently in the shifter (debug).
- `fifo_full`  out  1  FIFO holds fifo_depth entries.
- `overflow`  out  1  sticky: a symbol was dropped.
- `inv_sym`  out  1  sticky: an input was not an exact constellation point.
- `sym_count`  out  16  accepted-symbol counter, wraps 65535->0.

## Operation
- Classification per axis, value v:
  - sign = v[msb]
  - outer = (v >= 8192) or (v < -8192)
  - Gray code: -3 -> 00, -1 -> 01, +1 -> 11, +3 -> 10.
- Symbol = {I code, Q code}: bits [3:2] from x_in, [1:0] from y_in.
  - Example: (+3,-1) -> 4'b1001.
- inv_sym sets when sym_valid is high and either input is not exactly one of -12288, -4096, 4096, 12288. The symbol is still mapped by the classification rule and accepted.
- FIFO:
  - Push when sym_valid and (not full, or a pop occurs the same cycle).
  - If sym_valid arrives while full with no pop, the symbol is dropped, overflow is set, and sym_count does not increment.
  - sym_count increments on every push.
- Serializer FSM, with a 4-bit shift register and a 2-bit bit index:
  - IDLE: bit_valid=0. If the FIFO is non-empty, pop into the shifter, index=0, go to SHIFT.
  - SHIFT: bit_valid=1, bit_out=shifter[3-index]. On bit_valid && bit_ready, index++.
  - On the transfer of the 4th bit (index==3):
    - if the FIFO is non-empty, pop and reload in the same cycle (no bubble), index=0, stay in SHIFT;
    - otherwise go to IDLE.
  - bit_ready low holds bit_out, index and state unchanged (AXI-style; bit_valid never drops mid-symbol).
- Reset (any time, including mid-symbol):
  - FIFO emptied, state IDLE.
  - All outputs 0: bit_out, bit_valid, sym_out, fifo_full, overflow, inv_sym, sym_count.
  - Partial symbols are discarded.

## Timing
- FIFO write on the sym_valid edge; entry visible the next cycle.
- Serializer pops on the following edge; bit_valid first high 2 cycles after the sym_valid cycle when idle and empty.
- Throughput: 1 bit/cycle with bit_ready high. Sustained sym_valid faster than 1 per 4 cycles fills the FIFO.
- Simultaneous push and pop when full: both happen; count unchanged; fifo_full stays 1; no overflow.
- Simultaneous push and pop when empty: the push lands in the FIFO. The pop cannot return it that cycle because the FIFO is empty, so no pop occurs; the symbol pops next cycle.
- Pointers wrap modulo fifo_depth. fifo_full and empty derive from an occupancy counter of width log2(fifo_depth)+1.
- sym_out updates on each load and holds its value in IDLE.

## Test plan
- Single symbol: reset, then one cycle sym_valid with (12288,-4096), bit_ready=1.
  - bit_valid high 2 cycles later for 4 cycles, bits 1,0,0,1.
  - sym_count=1; returns to IDLE.
- All 16 points: feed the 16 exact points spaced 4 cycles apart.
  - The serial stream matches the Gray table, e.g. (-3,-3) -> 0000, (+1,+1) -> 1111.
  - Stream is gap-free after the first bit; inv_sym=0.
- Backpressure: 3 symbols back-to-back with bit_ready toggling 1,0,0,1.
  - bit_out stable while bit_ready=0; all 12 bits delivered in order, none lost or duplicated.
- Overflow: bit_ready=0 and 9 consecutive sym_valid with fifo_depth=8.
  - The shifter loads 1 symbol and the FIFO fills with 8, so fifo_full=1 and overflow stays 0.
  - A 10th sym_valid is dropped: overflow=1, sym_count=9.
  - Release bit_ready: exactly 36 bits are output.
- Invalid input: sym_valid with (5000,-9000).
  - inv_sym=1; symbol 11 for I, 00 for Q -> bits 1,1,0,0.
- Mid-symbol reset: assert rst_n=0 after 2 bits of a symbol.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, no residual bits appear until a new sym_valid.
